// File: rtl/ctrl_pipeline_if.sv
// ID-stage control/register fields into the pipeline and the EX/MEM/WB control, hazard
// and forwarding results coming back out.
interface ctrl_pipeline_if;
  logic [9:0] ctrl_i;
  logic [4:0] rs_i;
  logic [4:0] rt_i;
  logic [4:0] rd_i;
  logic       flush_i;
  logic       stall_o;
  logic [9:0] ex_ctrl_o;
  logic [4:0] ex_rs_o;
  logic [4:0] ex_rt_o;
  logic [3:0] mem_ctrl_o;
  logic [4:0] mem_wreg_o;
  logic [4:0] wb_wreg_o;
  logic [1:0] wb_ctrl_o;
  logic [1:0] fwdA_o;
  logic [1:0] fwdB_o;

  modport master (
    output ctrl_i, rs_i, rt_i, rd_i, flush_i,
    input  stall_o, ex_ctrl_o, ex_rs_o, ex_rt_o, mem_ctrl_o, mem_wreg_o, wb_wreg_o,
           wb_ctrl_o, fwdA_o, fwdB_o
  );

  modport slave (
    input  ctrl_i, rs_i, rt_i, rd_i, flush_i,
    output stall_o, ex_ctrl_o, ex_rs_o, ex_rt_o, mem_ctrl_o, mem_wreg_o, wb_wreg_o,
           wb_ctrl_o, fwdA_o, fwdB_o
  );
endinterface

// File: rtl/ctrl_pipeline.sv
// EX/MEM/WB control pipeline registers with load-use stall detection, flush bubbles and
// EX operand forwarding selection.
module ctrl_pipeline (
  input  logic          clk_i,
  input  logic          rst_i,
  ctrl_pipeline_if.slave bus
);

  logic [9:0] ex_ctrl_q;
  logic [4:0] ex_rs_q, ex_rt_q, ex_rd_q;
  logic [3:0] mem_ctrl_q;
  logic [4:0] mem_wreg_q;
  logic [1:0] wb_ctrl_q;
  logic [4:0] wb_wreg_q;

  logic [9:0] ctrl_clean;
  logic [4:0] ex_wreg;
  logic       stall;
  logic       bubble;
  logic [1:0] fwd_a, fwd_b;

  // Only a definite 1 survives capture, so unknown bits never reach the write enables.
  always_comb begin
    ctrl_clean = '0;
    for (int i = 0; i < 10; i++) begin
      ctrl_clean[i] = (bus.ctrl_i[i] === 1'b1);
    end
  end

  assign ex_wreg = ex_ctrl_q[9] ? ex_rd_q : ex_rt_q;

  always_comb begin
    stall = 1'b0;
    if (ex_ctrl_q[4] && (ex_wreg != 5'd0) &&
        ((ex_wreg == bus.rs_i) || (ex_wreg == bus.rt_i))) begin
      stall = 1'b1;
    end
  end

  assign bubble = stall | bus.flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_ctrl_q  <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_rd_q    <= '0;
      mem_ctrl_q <= '0;
      mem_wreg_q <= '0;
      wb_ctrl_q  <= '0;
      wb_wreg_q  <= '0;
    end else begin
      if (bubble) begin
        ex_ctrl_q <= '0;
        ex_rs_q   <= '0;
        ex_rt_q   <= '0;
        ex_rd_q   <= '0;
      end else begin
        ex_ctrl_q <= ctrl_clean;
        ex_rs_q   <= bus.rs_i;
        ex_rt_q   <= bus.rt_i;
        ex_rd_q   <= bus.rd_i;
      end
      mem_ctrl_q <= ex_ctrl_q[7:4];
      mem_wreg_q <= ex_wreg;
      wb_ctrl_q  <= mem_ctrl_q[3:2];
      wb_wreg_q  <= mem_wreg_q;
    end
  end

  // MEM is checked first so the younger result wins when both stages target one register.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_ctrl_q[2] && (mem_wreg_q != 5'd0) && (mem_wreg_q == ex_rs_q)) begin
      fwd_a = 2'b10;
    end else if (wb_ctrl_q[0] && (wb_wreg_q != 5'd0) && (wb_wreg_q == ex_rs_q)) begin
      fwd_a = 2'b01;
    end
    if (mem_ctrl_q[2] && (mem_wreg_q != 5'd0) && (mem_wreg_q == ex_rt_q)) begin
      fwd_b = 2'b10;
    end else if (wb_ctrl_q[0] && (wb_wreg_q != 5'd0) && (wb_wreg_q == ex_rt_q)) begin
      fwd_b = 2'b01;
    end
  end

  assign bus.stall_o    = stall;
  assign bus.ex_ctrl_o  = ex_ctrl_q;
  assign bus.ex_rs_o    = ex_rs_q;
  assign bus.ex_rt_o    = ex_rt_q;
  assign bus.mem_ctrl_o = mem_ctrl_q;
  assign bus.mem_wreg_o = mem_wreg_q;
  assign bus.wb_ctrl_o  = wb_ctrl_q;
  assign bus.wb_wreg_o  = wb_wreg_q;
  assign bus.fwdA_o     = fwd_a;
  assign bus.fwdB_o     = fwd_b;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: a reference model pushes expected pipeline state into a
// scoreboard at each drive, popped and compared one edge later, plus literal scenario checks.
module tb_ctrl_pipeline;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctrl_pipeline_if bus ();

  ctrl_pipeline dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [9:0] ex_ctrl;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [3:0] mem_ctrl;
    logic [4:0] mem_wreg;
    logic [1:0] wb_ctrl;
    logic [4:0] wb_wreg;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;

  localparam logic [9:0] LW    = 10'b0111010001;
  localparam logic [9:0] RTYPE = 10'b1001000010;
  localparam logic [9:0] NOP   = 10'b0000000000;

  // Reference model of the pipeline state.
  logic [9:0] m_ex_ctrl;
  logic [4:0] m_ex_rs, m_ex_rt, m_ex_rd;
  logic [3:0] m_mem_ctrl;
  logic [4:0] m_mem_wreg;
  logic [1:0] m_wb_ctrl;
  logic [4:0] m_wb_wreg;

  task automatic model_reset();
    m_ex_ctrl = '0; m_ex_rs = '0; m_ex_rt = '0; m_ex_rd = '0;
    m_mem_ctrl = '0; m_mem_wreg = '0; m_wb_ctrl = '0; m_wb_wreg = '0;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_of(input logic [4:0] src);
    if (m_mem_ctrl[2] && m_mem_wreg != 0 && m_mem_wreg == src) return 2'b10;
    if (m_wb_ctrl[0] && m_wb_wreg != 0 && m_wb_wreg == src) return 2'b01;
    return 2'b00;
  endfunction

  // Drive one ID bundle, check the expected stall, advance the model, clock, then score.
  task automatic step(input logic [9:0] c, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic f, input logic exp_stall);
    exp_t e;
    exp_t got;
    bus.ctrl_i = c; bus.rs_i = s; bus.rt_i = t; bus.rd_i = d; bus.flush_i = f;
    #1;
    chk("stall", {9'd0, bus.stall_o}, {9'd0, exp_stall});
    m_wb_ctrl  = m_mem_ctrl[3:2];
    m_wb_wreg  = m_mem_wreg;
    m_mem_ctrl = m_ex_ctrl[7:4];
    m_mem_wreg = m_ex_ctrl[9] ? m_ex_rd : m_ex_rt;
    if (f || exp_stall) begin
      m_ex_ctrl = '0; m_ex_rs = '0; m_ex_rt = '0; m_ex_rd = '0;
    end else begin
      for (int i = 0; i < 10; i++) m_ex_ctrl[i] = (c[i] === 1'b1);
      m_ex_rs = s; m_ex_rt = t; m_ex_rd = d;
    end
    e = '{ex_ctrl: m_ex_ctrl, ex_rs: m_ex_rs, ex_rt: m_ex_rt, mem_ctrl: m_mem_ctrl,
          mem_wreg: m_mem_wreg, wb_ctrl: m_wb_ctrl, wb_wreg: m_wb_wreg,
          fa: fwd_of(m_ex_rs), fb: fwd_of(m_ex_rt)};
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("ex_ctrl", bus.ex_ctrl_o, got.ex_ctrl);
    chk("ex_rs", {5'd0, bus.ex_rs_o}, {5'd0, got.ex_rs});
    chk("ex_rt", {5'd0, bus.ex_rt_o}, {5'd0, got.ex_rt});
    chk("mem_ctrl", {6'd0, bus.mem_ctrl_o}, {6'd0, got.mem_ctrl});
    chk("mem_wreg", {5'd0, bus.mem_wreg_o}, {5'd0, got.mem_wreg});
    chk("wb_ctrl", {8'd0, bus.wb_ctrl_o}, {8'd0, got.wb_ctrl});
    chk("wb_wreg", {5'd0, bus.wb_wreg_o}, {5'd0, got.wb_wreg});
    chk("fwdA", {8'd0, bus.fwdA_o}, {8'd0, got.fa});
    chk("fwdB", {8'd0, bus.fwdB_o}, {8'd0, got.fb});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ex"}, bus.ex_ctrl_o, 10'd0);
    chk({tag, "_mem"}, {6'd0, bus.mem_ctrl_o}, 10'd0);
    chk({tag, "_wb"}, {8'd0, bus.wb_ctrl_o}, 10'd0);
    chk({tag, "_regs"}, {bus.ex_rs_o, bus.ex_rt_o}, 10'd0);
    chk({tag, "_wregs"}, {bus.mem_wreg_o, bus.wb_wreg_o}, 10'd0);
    chk({tag, "_hz"}, {5'd0, bus.stall_o, bus.fwdA_o, bus.fwdB_o}, 10'd0);
  endtask

  initial begin
    model_reset();
    bus.ctrl_i = LW; bus.rs_i = 5'd2; bus.rt_i = 5'd2; bus.rd_i = 5'd3; bus.flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Load-use: lw $2, then add $3,$2,$4 stalls once and then gets the WB forward.
    step(LW, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    step(RTYPE, 5'd2, 5'd4, 5'd3, 1'b0, 1'b1);
    chk("lu_bubble", bus.ex_ctrl_o, 10'd0);
    step(RTYPE, 5'd2, 5'd4, 5'd3, 1'b0, 1'b0);
    chk("lu_fwdA", {8'd0, bus.fwdA_o}, 10'b01);
    step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // add $1 then sub $5,$1,$1: both operands from MEM, then nothing.
    step(RTYPE, 5'd7, 5'd8, 5'd1, 1'b0, 1'b0);
    step(RTYPE, 5'd1, 5'd1, 5'd5, 1'b0, 1'b0);
    chk("sub_fwd", {6'd0, bus.fwdA_o, bus.fwdB_o}, 10'b1010);
    step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("sub_after", {6'd0, bus.fwdA_o, bus.fwdB_o}, 10'b0000);
    step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // add $1; add $1; or $6,$1,$0: MEM beats WB, $0 never forwards.
    step(RTYPE, 5'd9, 5'd10, 5'd1, 1'b0, 1'b0);
    step(RTYPE, 5'd11, 5'd12, 5'd1, 1'b0, 1'b0);
    step(RTYPE, 5'd1, 5'd0, 5'd6, 1'b0, 1'b0);
    chk("or_fwd", {6'd0, bus.fwdA_o, bus.fwdB_o}, 10'b1000);

    // Flushed sw never produces a MemWrite.
    step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(10'bx1x01x0001, 5'd3, 5'd4, 5'd0, 1'b1, 1'b0);
    chk("flush_ex", bus.ex_ctrl_o, 10'd0);
    step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("flush_mw", {9'd0, bus.mem_ctrl_o[1]}, 10'd0);

    // Flush and stall together: one bubble, stall still seen, then normal flow.
    step(LW, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0);
    step(RTYPE, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1);
    step(RTYPE, 5'd8, 5'd6, 5'd7, 1'b0, 1'b0);
    chk("fs_accept", bus.ex_ctrl_o, RTYPE);

    // beq with unknown bits: captured cleanly with Branch and ALUOp[1] set.
    step(10'bx0x0001x1x, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    chk("beq_ctrl", bus.ex_ctrl_o, 10'b0000001010);

    // Mid-flight reset while a lw sits in MEM.
    step(LW, 5'd1, 5'd9, 5'd0, 1'b0, 1'b0);
    step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("lw_in_mem", {6'd0, bus.mem_ctrl_o}, 10'b1101);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    #1;
    rst = 1'b0;
    model_reset();
    step(RTYPE, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0);
    chk("post_rst_wb", {8'd0, bus.wb_ctrl_o}, 10'd0);
    chk("post_rst_mem", {6'd0, bus.mem_ctrl_o}, 10'd0);
    chk("post_rst_accept", bus.ex_ctrl_o, RTYPE);
    step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
